// File: rtl/apb_2_lint_pkg.sv
// rtl/apb_2_lint_pkg.sv - default widths shared by the APB-to-LINT bridge
package apb_2_lint_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 10;
  localparam int DEF_AUX_WIDTH  = 8;

endpackage

// File: rtl/apb_2_lint.sv
// rtl/apb_2_lint.sv - APB slave to LINT master bridge, one outstanding transfer
module apb_2_lint
  import apb_2_lint_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int AUX_WIDTH  = DEF_AUX_WIDTH,
  parameter int ID_VALUE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] slave_PADDR,
  input  logic [DATA_WIDTH-1:0] slave_PWDATA,
  input  logic                  slave_PWRITE,
  input  logic                  slave_PSEL,
  input  logic                  slave_PENABLE,
  output logic [DATA_WIDTH-1:0] slave_PRDATA,
  output logic                  slave_PREADY,
  output logic                  slave_PSLVERR,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [AUX_WIDTH-1:0]  data_aux_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
  input  logic [ID_WIDTH-1:0]   data_r_ID_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID, RESP} state_e;

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;

  // The FSM leaves IDLE on PSEL alone; PENABLE and the LINT response tags carry no information here.
  logic w_unused;
  assign w_unused = ^{slave_PENABLE, data_r_aux_i, data_r_ID_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && slave_PSEL) begin
        r_paddr  <= slave_PADDR;
        r_pwdata <= slave_PWDATA;
        r_pwrite <= slave_PWRITE;
      end
      if (r_state == WAIT_RVALID && data_r_valid_i) begin
        r_prdata  <= data_r_rdata_i;
        r_pslverr <= data_r_opc_i;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    data_req_o   = 1'b0;
    slave_PREADY = 1'b0;
    case (r_state)
      IDLE: begin
        if (slave_PSEL) w_next = REQ;
      end
      REQ: begin
        // Held until granted even if the APB master abandons the transfer.
        data_req_o = 1'b1;
        if (data_gnt_i) w_next = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_r_valid_i) w_next = RESP;
      end
      RESP: begin
        slave_PREADY = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign data_add_o    = r_paddr;
  assign data_wdata_o  = r_pwdata;
  assign data_wen_o    = ~r_pwrite;
  assign data_be_o     = '1;
  assign data_aux_o    = '0;
  assign data_ID_o     = ID_WIDTH'(ID_VALUE);
  assign slave_PRDATA  = r_prdata;
  assign slave_PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_2_lint.sv
// tb/tb_apb_2_lint.sv - self-checking bench for the APB-to-LINT bridge
module tb_apb_2_lint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  logic        req, wen, gnt, rvalid, opc;
  logic [31:0] add, wdata, rdata;
  logic [3:0]  be;
  logic [7:0]  aux, r_aux;
  logic [9:0]  id, r_id;

  int checks = 0;
  int errors = 0;

  // Reference state: last response registered by the bridge.
  logic [31:0] m_prdata;
  logic        m_perr;

  apb_2_lint dut (
    .clk(clk), .rst_n(rst_n),
    .slave_PADDR(paddr), .slave_PWDATA(pwdata), .slave_PWRITE(pwrite),
    .slave_PSEL(psel), .slave_PENABLE(penable),
    .slave_PRDATA(prdata), .slave_PREADY(pready), .slave_PSLVERR(pslverr),
    .data_req_o(req), .data_add_o(add), .data_wen_o(wen), .data_wdata_o(wdata),
    .data_be_o(be), .data_aux_o(aux), .data_ID_o(id),
    .data_gnt_i(gnt), .data_r_valid_i(rvalid), .data_r_rdata_i(rdata),
    .data_r_opc_i(opc), .data_r_aux_i(r_aux), .data_r_ID_i(r_id)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int g, input int r);
    return 3 + g + r;
  endfunction

  // Plays APB master and LINT slave for one transfer; returns what it observed.
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                          input int g, input int r, input logic [31:0] rd, input logic e,
                          input bit drop_psel, output int lat, output logic [31:0] prd,
                          output logic perr, output int nbad, output bit tmo);
    int k, phase, gc, rc;
    bit seen, done;
    k = 0; phase = 0; gc = 0; rc = 0; seen = 0; done = 0;
    lat = -1; prd = 'x; perr = 1'bx; nbad = 0;
    paddr = a; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
    while (!done && k < 64) begin
      @(posedge clk); @(negedge clk); k++;
      if (k == 1) begin
        if (drop_psel) psel = 1'b0; else penable = 1'b1;
      end
      if (seen) begin
        if (pready !== 1'b0) nbad++;
        if (prdata !== prd) nbad++;
        psel = 1'b0; penable = 1'b0; done = 1;
      end else if (pready === 1'b1) begin
        seen = 1; lat = k; prd = prdata; perr = pslverr;
      end else begin
        case (phase)
          0: begin
            if (req !== 1'b1 || add !== a || wen !== ~wr || wdata !== wd ||
                be !== 4'hF || aux !== 8'h0 || id !== 10'h0) nbad++;
            if (gc == g) begin gnt = 1'b1; phase = 1; end
            else begin gnt = 1'b0; gc++; end
          end
          1: begin
            gnt = 1'b0;
            if (req !== 1'b0) nbad++;
            if (rc == r) begin rvalid = 1'b1; rdata = rd; opc = e; phase = 2; end
            else rc++;
          end
          default: begin
            rvalid = 1'b0; rdata = $urandom; opc = $urandom_range(1);
          end
        endcase
      end
      if (phase == 2 && rvalid && k > 0 && !seen && pready === 1'b0 && rc != -1) begin
        // Response is driven for exactly one sampled edge.
        rc = -1;
      end else if (rc == -1) begin
        rvalid = 1'b0;
      end
    end
    gnt = 1'b0; rvalid = 1'b0;
    tmo = !done;
    if (done) begin m_prdata = rd; m_perr = e; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    gnt = 0; rvalid = 0; rdata = 0; opc = 0; r_aux = 0; r_id = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_prdata = '0; m_perr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req, pready, pslverr} !== 3'b000 || prdata !== 32'h0 || add !== 32'h0 ||
        wdata !== 32'h0 || wen !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: req=%b pready=%b pslverr=%b prdata=%h add=%h wdata=%h wen=%b, expected 0 0 0 0 0 0 1",
               req, pready, pslverr, prdata, add, wdata, wen);
    end
  endtask

  task automatic check_xfer(input string nm, input int el, input logic [31:0] ed, input bit chk_d,
                            input logic ee, input int lat, input logic [31:0] prd,
                            input logic perr, input int nbad, input bit tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL %s_timeout: no completion, expected PREADY within bound", nm); end
    checks++;
    if (lat != el) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, el); end
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL %s_protocol: %0d bad request/pulse cycles, expected 0", nm, nbad); end
    if (chk_d) begin
      checks++;
      if (prd !== ed) begin errors++; $display("FAIL %s_prdata: got %h expected %h", nm, prd, ed); end
    end
    checks++;
    if (perr !== ee) begin errors++; $display("FAIL %s_pslverr: got %b expected %b", nm, perr, ee); end
  endtask

  task automatic test_read();
    int lat, nbad; logic [31:0] prd; logic perr; bit tmo;
    run_xfer(32'h1000_0040, $urandom, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0, 0, lat, prd, perr, nbad, tmo);
    check_xfer("read", exp_lat(0, 0), 32'hDEADBEEF, 1, 1'b0, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_write_stall();
    int lat, nbad; logic [31:0] prd; logic perr; bit tmo;
    run_xfer(32'h2000_0100, 32'h1234_5678, 1'b1, 3, 0, $urandom, 1'b0, 0, lat, prd, perr, nbad, tmo);
    check_xfer("write_stall", exp_lat(3, 0), 32'h0, 0, 1'b0, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_error();
    int lat, nbad; logic [31:0] prd; logic perr; bit tmo;
    run_xfer(32'h3000_0008, $urandom, 1'b0, 1, 2, 32'h0BAD_F00D, 1'b1, 0, lat, prd, perr, nbad, tmo);
    check_xfer("error", exp_lat(1, 2), 32'h0BAD_F00D, 1, 1'b1, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_psel_drop();
    int lat, nbad; logic [31:0] prd; logic perr; bit tmo;
    run_xfer(32'h4000_0004, $urandom, 1'b0, 2, 1, 32'hA5A5_0001, 1'b0, 1, lat, prd, perr, nbad, tmo);
    check_xfer("psel_drop", exp_lat(2, 1), 32'hA5A5_0001, 1, 1'b0, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_reset_mid();
    int lat, nbad, bad; logic [31:0] prd; logic perr; bit tmo;
    bad = 0;
    paddr = 32'h5000_0000; pwdata = 32'h1; pwrite = 1'b0; psel = 1'b1;
    @(posedge clk); @(negedge clk); gnt = 1'b1;
    @(posedge clk); @(negedge clk); gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || add !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: req=%b pready=%b prdata=%h pslverr=%b add=%h, expected all 0",
               req, pready, prdata, pslverr, add);
    end
    psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = $urandom; opc = 1'b1;
      @(posedge clk); @(negedge clk);
      if (pready !== 1'b0 || req !== 1'b0) bad++;
    end
    rst_n = 1'b1; rvalid = 1'b0;
    m_prdata = '0; m_perr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      if (pready !== 1'b0 || req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_quiet: %0d cycles with req/PREADY high, expected 0", bad); end
    run_xfer(32'h5000_0010, $urandom, 1'b0, 0, 1, 32'h7777_1111, 1'b0, 0, lat, prd, perr, nbad, tmo);
    check_xfer("after_reset", exp_lat(0, 1), 32'h7777_1111, 1, 1'b0, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_stray_back_to_back();
    int lat, nbad, bad; logic [31:0] prd; logic perr; bit tmo;
    bad = 0;
    rvalid = 1'b1; rdata = 32'h55AA_55AA; opc = ~m_perr;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      if (pready !== 1'b0 || req !== 1'b0 || prdata !== m_prdata || pslverr !== m_perr) bad++;
    end
    rvalid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stray_rvalid: %0d cycles disturbed, expected 0", bad); end
    run_xfer(32'h6000_0000, $urandom, 1'b0, 0, 0, 32'h1111_2222, 1'b0, 0, lat, prd, perr, nbad, tmo);
    check_xfer("b2b_first", exp_lat(0, 0), 32'h1111_2222, 1, 1'b0, lat, prd, perr, nbad, tmo);
    run_xfer(32'h6000_0004, $urandom, 1'b0, 0, 0, 32'h3333_4444, 1'b0, 0, lat, prd, perr, nbad, tmo);
    check_xfer("b2b_second", exp_lat(0, 0), 32'h3333_4444, 1, 1'b0, lat, prd, perr, nbad, tmo);
  endtask

  task automatic test_random();
    int lat, nbad, g, r; logic [31:0] prd, a, wd, rd; logic perr, wr, e; bit tmo;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom; wr = $urandom_range(1); e = $urandom_range(1);
      g = $urandom_range(3); r = $urandom_range(3);
      run_xfer(a, wd, wr, g, r, rd, e, 0, lat, prd, perr, nbad, tmo);
      check_xfer("random", exp_lat(g, r), rd, !wr, e, lat, prd, perr, nbad, tmo);
      if ($urandom_range(1)) repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_error();
    test_psel_drop();
    test_reset_mid();
    test_stray_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_2_lint.md
APB_2_LINT -- requirements
Module: apb_2_lint

Interface
REQ-001 Parameters SHALL be:
  - ADDR_WIDTH, 32, address width
  - DATA_WIDTH, 32, data width
  - BE_WIDTH, DATA_WIDTH/8, byte-enable width
  - ID_WIDTH, 10, LINT ID width
  - AUX_WIDTH, 8, LINT aux width
  - ID_VALUE, 0, constant driven on data_ID_o
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports (name, direction, width, meaning):
  - clk  in  1  clock
  - rst_n  in  1  async active-low reset
  - slave_PADDR  in  ADDR_WIDTH  APB address
  - slave_PWDATA  in  DATA_WIDTH  APB write data
  - slave_PWRITE  in  1  1=write
  - slave_PSEL  in  1  select
  - slave_PENABLE  in  1  access phase
  - slave_PRDATA  out  DATA_WIDTH  read data
  - slave_PREADY  out  1  transfer done
  - slave_PSLVERR  out  1  error
  - data_req_o  out  1  LINT request
  - data_add_o  out  ADDR_WIDTH  LINT address
  - data_wen_o  out  1  0=write, 1=read
  - data_wdata_o  out  DATA_WIDTH  write data
  - data_be_o  out  BE_WIDTH  byte enables
  - data_aux_o  out  AUX_WIDTH  aux
  - data_ID_o  out  ID_WIDTH  ID
  - data_gnt_i  in  1  grant
  - data_r_valid_i  in  1  response valid
  - data_r_rdata_i  in  DATA_WIDTH  response data
  - data_r_opc_i  in  1  response error
  - data_r_aux_i  in  AUX_WIDTH  unused
  - data_r_ID_i  in  ID_WIDTH  unused

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT_RVALID and RESP.
REQ-005 IDLE: PREADY=0 and req=0; if PSEL=1, capture PADDR, PWDATA and PWRITE into registers and go to REQ; otherwise stay in IDLE.
REQ-006 REQ: req=1 with the registered add/wdata; wen = ~PWRITE_q; be all ones; aux '0; ID = ID_VALUE. When gnt=1, go to WAIT_RVALID; otherwise stay in REQ with all outputs stable.
REQ-007 WAIT_RVALID: req=0; when r_valid=1, register rdata into PRDATA_q and opc into PSLVERR_q, then go to RESP.
REQ-008 RESP: PREADY=1 for exactly one cycle, PRDATA=PRDATA_q, PSLVERR=PSLVERR_q; next state is IDLE.
REQ-009 PRDATA_q and PSLVERR_q SHALL hold their values until the next r_valid; PREADY=0 in every state except RESP.
REQ-010 Minimum timing: PSEL at cycle T0, gnt at T1, r_valid at T2, PREADY=1 at T3; each additional gnt or r_valid wait cycle adds one cycle.
REQ-011 r_valid SHALL be ignored outside WAIT_RVALID; r_valid in the same cycle as gnt SHALL NOT be supported.
REQ-012 Once asserted, req SHALL be held until gnt even if PSEL drops (APB protocol violation); the transaction completes and FSM returns to IDLE.
REQ-013 After RESP, a new transfer SHALL NOT start before IDLE is re-entered, so back-to-back transfers need at least 4 cycles each.
REQ-014 Write transfers SHALL also wait for r_valid; the write response carries opc into PSLVERR and PRDATA is don't-care.

Reset
REQ-015 On rst_n=0 (asynchronous):
  - FSM goes to IDLE
  - req, PREADY and PSLVERR = 0
  - PRDATA and captured address/wdata/write registers = '0
REQ-016 Reset mid-transfer SHALL abort it without any PREADY pulse; the first cycle after release is IDLE.

Structure
REQ-017 The state enum SHALL be local to the module; no shared package is required.
REQ-018 The block SHALL be a single module with no sub-module: one always_ff and one always_comb.

Verification
REQ-019 Read: PADDR=0x1000_0040, PWRITE=0, gnt immediate, r_valid next cycle with rdata=0xDEADBEEF -> add_o=0x1000_0040, wen_o=1, PREADY high at T3, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-020 Write: PWDATA=0x1234_5678, PWRITE=1, gnt stalled 3 cycles -> req and outputs stable for 4 cycles, wen_o=0, be_o=0xF, PREADY one cycle after r_valid.
REQ-021 Error: r_valid with opc=1 -> PSLVERR=1 together with PREADY.
REQ-022 Reset: assert rst_n in WAIT_RVALID -> req=0, PREADY never asserts; the next transfer after release completes normally.
REQ-023 Stray/back-to-back: r_valid pulse in IDLE is ignored; two consecutive reads each complete with their own data and PREADY pulse width is 1.
